fx3_stream_arbiter: RTL and testbench
=====================================

# fx3_stream_arbiter

Round-robin packet arbiter that shares the single 16-bit FX3 transmit stream between NCH independent stream sources. It sits directly upstream of the FX3 GPIF transmit block: its master port drives that block's stream input, and its slave ports take per-channel sources such as ADC capture FIFOs and register readback. Each granted burst is prefixed with one header word that identifies the channel. Bursts are capped at MAX_BURST words so that no single source can starve the others.

## Interface
- NCH, 4: number of source channels, 2..16.
- MAX_BURST, 256: maximum data words per burst, 1..65535. Counter width is clog2(MAX_BURST+1).
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_data_i  in  16*NCH  channel c data in bits [16c+15:16c].
- s_valid_i  in  NCH  per-channel data valid.
- s_last_i  in  NCH  per-channel end-of-packet flag, qualified by valid.
- s_ready_o  out  NCH  per-channel ready.
- m_data_o  out  16  output stream data to the FX3 transmit block.
- m_valid_o  out  1  output valid.
- m_ready_i  in  1  output ready from the FX3 transmit block.
- busy_o  out  1  high in the HDR and DATA states.
- grant_o  out  4  channel currently granted; holds its last value when idle.

## Operation
- Handshake: a word moves when valid and ready are both high in the same cycle. A source must hold data and last stable while valid=1 and ready=0.
- FSM states are IDLE, HDR and DATA. Reset puts the FSM in IDLE.
- IDLE:
  - m_valid_o=0 and all s_ready_o=0.
  - If any s_valid_i bit is high, register grant = the first valid channel found by searching upward from rr_ptr, with wrap-around.
  - Go to HDR and clear the burst counter.
- HDR:
  - m_valid_o=1.
  - m_data_o = {8'hA5, cont[grant], 3'b000, grant[3:0]}.
  - All s_ready_o=0.
  - On m_ready_i=1, go to DATA.
- DATA, combinational pass-through of the granted channel only:
  - m_data_o = s_data_i[grant].
  - m_valid_o = s_valid_i[grant].
  - s_ready_o[grant] = m_ready_i; all other s_ready_o bits are 0.
- Each DATA transfer increments the burst counter. The burst ends on the transfer that either:
  - has s_last_i[grant]=1, which clears cont[grant]; or
  - makes the count equal MAX_BURST without last, which sets cont[grant].
  - If both hold on the same transfer, last wins and cont[grant] is cleared.
- At burst end: rr_ptr <= grant+1, wrapping to 0 after NCH-1; then go to IDLE.
- A source that drops valid during DATA does not release the grant. The FSM waits in DATA with m_valid_o=0.
- Zero-length bursts cannot occur. HDR is only entered on a valid word, and that word's holder keeps the grant.
- cont[c] marks a header whose burst continues a packet that was cut at MAX_BURST.
- Reset values: m_valid_o=0, s_ready_o=0, m_data_o=16'h0000 (driven 0 when IDLE), busy_o=0, grant_o=0, rr_ptr=0, cont=0, counter=0.
- rst asserted mid-burst aborts the burst at once. The partial packet is not completed, and on the next grant it gets a header with cont=0.

## Timing
- Arbitration latency: s_valid_i rising in cycle N puts the header on m_data_o with m_valid_o=1 in cycle N+1.
- Header-to-data: if the header is accepted in cycle M, the first data word is presented in cycle M+1.
- Data path latency is 0 cycles: data, valid and ready are combinational through the arbiter.
- Inter-burst gap: exactly one IDLE cycle after the last transfer of a burst, then the next header.
- Throughput with continuous valid and ready is MAX_BURST words per MAX_BURST+2 cycles.
- m_ready_i low stalls HDR or DATA indefinitely. No state changes while stalled.
- s_valid_i and s_last_i of non-granted channels are ignored until the next IDLE cycle.
- Fairness: with all channels continuously valid, grants cycle 0,1,...,NCH-1,0,...

## Test plan
- Single channel: ch2 sends 3 words 0x1111, 0x2222, 0x3333 with last on the third, m_ready_i=1. Required output: 0xA502, 0x1111, 0x2222, 0x3333. Then one IDLE cycle; busy_o rises and falls accordingly.
- Round robin, NCH=4, all channels valid with 1-word packets (last=1). Required header sequence: 0xA500, 0xA501, 0xA502, 0xA503, 0xA500. Each header is followed by that channel's word.
- MAX_BURST=4: ch1 streams 6 words with last on word 6. Required output:
  - header 0xA501, then words 1-4;
  - IDLE;
  - header 0xA581 (cont=1), then words 5-6;
  - cont[1] clear afterwards.
- Backpressure: toggle m_ready_i randomly during a ch3 8-word packet. Required:
  - no word duplicated or dropped;
  - data is held stable while m_ready_i=0;
  - s_ready_o[3] equals m_ready_i in DATA.
- Source gap plus competing valid: ch0 drops valid for 5 cycles mid-packet while ch1 is valid. Required: the grant stays on ch0, s_ready_o[1]=0 throughout, and ch1's header follows ch0's last word plus one IDLE cycle.
- Async reset mid-burst: assert rst in DATA. Required, in the same cycle without a clock edge: m_valid_o=0 and all s_ready_o=0. After release, the first header uses rr_ptr=0 with cont=0.

Source files
------------

// File: rtl/fx3_stream_arbiter_if.sv
// Stream bundle between NCH per-channel sources, the arbiter and the FX3
// transmit block. The master view belongs to the arbiter; the slave view
// belongs to whatever drives the sources and consumes the output stream.
interface fx3_stream_arbiter_if #(
  parameter int unsigned NCH = 4
) ();
  logic [16*NCH-1:0] s_data_i;
  logic [NCH-1:0]    s_valid_i;
  logic [NCH-1:0]    s_last_i;
  logic [NCH-1:0]    s_ready_o;
  logic [15:0]       m_data_o;
  logic              m_valid_o;
  logic              m_ready_i;

  modport master (
    input  s_data_i, s_valid_i, s_last_i, m_ready_i,
    output s_ready_o, m_data_o, m_valid_o
  );

  modport slave (
    output s_data_i, s_valid_i, s_last_i, m_ready_i,
    input  s_ready_o, m_data_o, m_valid_o
  );
endinterface

// File: rtl/fx3_stream_arbiter.sv
// Round-robin packet arbiter sharing the 16-bit FX3 transmit stream between
// NCH sources. Each burst is prefixed by a header {A5, cont, 000, channel};
// bursts are capped at MAX_BURST words, and a capped packet's next header
// carries cont=1. Data, valid and ready pass through combinationally.
module fx3_stream_arbiter #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned MAX_BURST = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  fx3_stream_arbiter_if.master strm,
  output logic                 busy_o,
  output logic [3:0]           grant_o
);

  localparam int unsigned     CW      = $clog2(MAX_BURST + 1);
  localparam int unsigned     IW      = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t          state_q, state_d;
  logic [3:0]      grant_q, grant_d;
  logic [3:0]      rr_q, rr_d;
  logic [NCH-1:0]  cont_q, cont_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [15:0]     chan_data [NCH];
  logic [IW-1:0]   g_idx;
  logic [3:0]      pick;
  logic            any_valid;
  logic [CW-1:0]   cnt_inc;
  logic            burst_end;
  logic [15:0]     m_data;
  logic            m_valid;
  logic [NCH-1:0]  s_ready;

  for (genvar c = 0; c < NCH; c++) begin : g_split
    assign chan_data[c] = strm.s_data_i[16*c +: 16];
  end

  assign g_idx   = IW'(grant_q);
  assign cnt_inc = cnt_q + CW'(1);

  // Pick the first valid channel at or above rr_q, wrapping past NCH-1.
  always_comb begin
    pick      = rr_q;
    any_valid = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      int unsigned idx;
      idx = 32'(rr_q) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (!any_valid && strm.s_valid_i[IW'(idx)]) begin
        any_valid = 1'b1;
        pick      = 4'(idx);
      end
    end
  end

  // Next-state logic and stream muxing for IDLE/HDR/DATA.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    cont_d    = cont_q;
    cnt_d     = cnt_q;
    burst_end = 1'b0;
    m_data    = '0;
    m_valid   = 1'b0;
    s_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        m_valid = 1'b1;
        m_data  = {8'hA5, cont_q[g_idx], 3'b000, grant_q};
        if (strm.m_ready_i) state_d = DATA;
      end
      DATA: begin
        m_data         = chan_data[g_idx];
        m_valid        = strm.s_valid_i[g_idx];
        s_ready[g_idx] = strm.m_ready_i;
        if (strm.s_valid_i[g_idx] && strm.m_ready_i) begin
          cnt_d = cnt_inc;
          // Last takes priority over hitting the cap on the same word.
          if (strm.s_last_i[g_idx]) begin
            cont_d[g_idx] = 1'b0;
            burst_end     = 1'b1;
          end else if (cnt_inc == MAX_CNT) begin
            cont_d[g_idx] = 1'b1;
            burst_end     = 1'b1;
          end
          if (burst_end) begin
            rr_d    = (grant_q == 4'(NCH - 1)) ? 4'd0 : grant_q + 4'd1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant, round-robin pointer, continuation flags and burst count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cont_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cont_q  <= cont_d;
      cnt_q   <= cnt_d;
    end
  end

  assign strm.m_data_o  = m_data;
  assign strm.m_valid_o = m_valid;
  assign strm.s_ready_o = s_ready;
  assign busy_o         = (state_q != IDLE);
  assign grant_o        = grant_q;

endmodule

// File: tb/tb_fx3_stream_arbiter.sv
// Bench for fx3_stream_arbiter (NCH=4, MAX_BURST=4): a cycle table for the
// single-channel and header-stall timing, hand sequences for round robin,
// burst capping, backpressure, source gaps and async reset, and randomized
// traffic checked against a queue-based reference of the arbitration rules.
module tb_fx3_stream_arbiter;
  localparam int NCH  = 4;
  localparam int MAXB = 4;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [3:0] grant;

  fx3_stream_arbiter_if #(.NCH(NCH)) bus ();

  fx3_stream_arbiter #(.NCH(NCH), .MAX_BURST(MAXB)) dut (
    .clk    (clk),
    .rst    (rst),
    .strm   (bus),
    .busy_o (busy),
    .grant_o(grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        last;
    logic [15:0] d;
  } word_t;

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [15:0] data;
    logic        rdy;
    logic        e_mv;
    logic [15:0] e_md;
    logic [3:0]  e_sr;
    logic        e_busy;
    logic [3:0]  e_gr;
  } vec_t;

  word_t       srcq [NCH][$];
  logic [15:0] expq [$];
  int          expch[$];

  int          checks = 0;
  int          errors = 0;
  int          model_rr;
  logic [NCH-1:0] model_cont;
  int          model_last_grant;

  bit          pop_pend [NCH];
  int          popped   [NCH];
  int          gap_at   [NCH];
  int          gap_left [NCH];
  int          gap_len = 5;
  bit          rand_rdy;
  bit          held;
  logic [15:0] held_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_src();
    logic [15:0]    sd [NCH];
    logic [NCH-1:0] sv;
    logic [NCH-1:0] sl;
    sv = '0;
    sl = '0;
    for (int c = 0; c < NCH; c++) begin
      sd[c] = 16'h0000;
      if (srcq[c].size() > 0) begin
        sd[c]      = srcq[c][0].d;
        sl[2'(c)]  = srcq[c][0].last;
        sv[2'(c)]  = (gap_left[c] == 0);
      end
    end
    bus.s_data_i  = {sd[3], sd[2], sd[1], sd[0]};
    bus.s_valid_i = sv;
    bus.s_last_i  = sl;
  endtask

  // Called just after a rising edge: retire accepted words, then re-drive.
  task automatic drive_update();
    word_t w;
    for (int c = 0; c < NCH; c++)
      if (gap_left[c] > 0) gap_left[c]--;
    for (int c = 0; c < NCH; c++) begin
      if (pop_pend[c]) begin
        if (srcq[c].size() > 0) w = srcq[c].pop_front();
        popped[c]++;
        if (popped[c] == gap_at[c]) gap_left[c] = gap_len;
        pop_pend[c] = 1'b0;
      end
    end
    bus.m_ready_i = rand_rdy ? ($urandom_range(0, 99) < 60) : 1'b1;
    apply_src();
  endtask

  // Called at the falling edge: protocol checks plus scoreboard compare.
  task automatic sample_check(output bit done);
    logic [3:0] exp_sr;
    int         ch;
    if (expq.size() > 0) begin
      ch     = expch[0];
      exp_sr = 4'b0000;
      if (ch >= 0 && bus.m_ready_i) exp_sr[2'(ch)] = 1'b1;
      chk((ch < 0) ? "sready_hdr" : "sready_data", 32'(bus.s_ready_o), 32'(exp_sr));
    end
    if (held) begin
      chk("hold_valid", 32'(bus.m_valid_o), 32'(1));
      chk("hold_data", 32'(bus.m_data_o), 32'(held_d));
    end
    held   = bus.m_valid_o && !bus.m_ready_i;
    held_d = bus.m_data_o;
    if (bus.m_valid_o && bus.m_ready_i) begin
      if (expq.size() == 0) begin
        chk("extra_word", 32'(bus.m_data_o), 32'hFFFF_FFFF);
      end else begin
        chk("stream_word", 32'(bus.m_data_o), 32'(expq[0]));
        expq.delete(0);
        expch.delete(0);
      end
    end
    for (int c = 0; c < NCH; c++)
      pop_pend[c] = bus.s_valid_i[2'(c)] && bus.s_ready_o[2'(c)];
    done = (expq.size() == 0);
  endtask

  task automatic run_stream(input string name, input int budget, output int cycles);
    bit done;
    held = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      pop_pend[c] = 1'b0;
      popped[c]   = 0;
      gap_left[c] = 0;
    end
    drive_update();
    cycles = 0;
    done   = (expq.size() == 0);
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      sample_check(done);
      if (!done) begin
        @(posedge clk);
        #1;
        drive_update();
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d words still expected after %0d cycles", name, expq.size(), cycles);
      expq.delete();
      expch.delete();
      for (int c = 0; c < NCH; c++) srcq[c].delete();
    end
    @(posedge clk);
    #1;
    drive_update();
  endtask

  task automatic load(input int c, input logic [15:0] d, input bit last);
    srcq[c].push_back({last, d});
  endtask

  task automatic push_hdr(input int c, input bit cont);
    expq.push_back({8'hA5, cont, 3'b000, 4'(c)});
    expch.push_back(-1);
  endtask

  task automatic push_dat(input int c, input logic [15:0] d);
    expq.push_back(d);
    expch.push_back(c);
  endtask

  // Reference: serve queued packets in round-robin order, one header per
  // burst, at most MAXB words per burst, cont set when a burst is capped.
  task automatic model_build();
    int    pos [NCH];
    bit    pending;
    int    c;
    int    n;
    word_t w;
    for (int k = 0; k < NCH; k++) pos[k] = 0;
    for (int guard = 0; guard < 10000; guard++) begin
      pending = 1'b0;
      c = 0;
      for (int k = 0; k < NCH; k++) begin
        int cc;
        cc = (model_rr + k) % NCH;
        if (!pending && pos[cc] < srcq[cc].size()) begin
          pending = 1'b1;
          c = cc;
        end
      end
      if (!pending) break;
      push_hdr(c, model_cont[2'(c)]);
      n = 0;
      while (pos[c] < srcq[c].size()) begin
        w = srcq[c][pos[c]];
        pos[c]++;
        n++;
        push_dat(c, w.d);
        if (w.last) begin
          model_cont[2'(c)] = 1'b0;
          break;
        end
        if (n == MAXB) begin
          model_cont[2'(c)] = 1'b1;
          break;
        end
      end
      model_rr         = (c + 1) % NCH;
      model_last_grant = c;
    end
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < NCH; c++) srcq[c].delete();
    bus.s_data_i  = '0;
    bus.s_valid_i = '0;
    bus.s_last_i  = '0;
    bus.m_ready_i = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_mvalid"}, 32'(bus.m_valid_o), 32'(0));
    chk({tag, "_sready"}, 32'(bus.s_ready_o), 32'(0));
    chk({tag, "_mdata"},  32'(bus.m_data_o),  32'(0));
    chk({tag, "_busy"},   32'(busy),          32'(0));
    chk({tag, "_grant"},  32'(grant),         32'(0));
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    #1;
    reset_checks("reset");
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    model_rr   = 0;
    model_cont = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [13];
    int   cyc;
    int   total;

    vecs[0]  = '{4'b0100, 4'b0000, 16'h1111, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'd0};
    vecs[1]  = '{4'b0100, 4'b0000, 16'h1111, 1'b1, 1'b1, 16'hA502, 4'b0000, 1'b1, 4'd2};
    vecs[2]  = '{4'b0100, 4'b0000, 16'h1111, 1'b1, 1'b1, 16'h1111, 4'b0100, 1'b1, 4'd2};
    vecs[3]  = '{4'b0100, 4'b0000, 16'h2222, 1'b1, 1'b1, 16'h2222, 4'b0100, 1'b1, 4'd2};
    vecs[4]  = '{4'b0100, 4'b0100, 16'h3333, 1'b1, 1'b1, 16'h3333, 4'b0100, 1'b1, 4'd2};
    vecs[5]  = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'd2};
    vecs[6]  = '{4'b0010, 4'b0010, 16'h7777, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'd2};
    vecs[7]  = '{4'b0010, 4'b0010, 16'h7777, 1'b0, 1'b1, 16'hA501, 4'b0000, 1'b1, 4'd1};
    vecs[8]  = '{4'b0010, 4'b0010, 16'h7777, 1'b1, 1'b1, 16'hA501, 4'b0000, 1'b1, 4'd1};
    vecs[9]  = '{4'b0010, 4'b0010, 16'h7777, 1'b0, 1'b1, 16'h7777, 4'b0000, 1'b1, 4'd1};
    vecs[10] = '{4'b0010, 4'b0010, 16'h7777, 1'b1, 1'b1, 16'h7777, 4'b0010, 1'b1, 4'd1};
    vecs[11] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'd1};
    vecs[12] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'd1};

    for (int c = 0; c < NCH; c++) gap_at[c] = -1;
    rand_rdy = 1'b0;
    rst = 1'b0;
    clear_inputs();
    #3;
    apply_reset();

    // Cycle table: ch2 three-word packet, then ch1 with a stalled header.
    for (int i = 0; i < 13; i++) begin
      bus.s_valid_i = vecs[i].valid;
      bus.s_last_i  = vecs[i].last;
      bus.s_data_i  = {4{vecs[i].data}};
      bus.m_ready_i = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d_mvalid", i), 32'(bus.m_valid_o), 32'(vecs[i].e_mv));
      chk($sformatf("vec%0d_mdata", i),  32'(bus.m_data_o),  32'(vecs[i].e_md));
      chk($sformatf("vec%0d_sready", i), 32'(bus.s_ready_o), 32'(vecs[i].e_sr));
      chk($sformatf("vec%0d_busy", i),   32'(busy),          32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_grant", i),  32'(grant),         32'(vecs[i].e_gr));
      @(posedge clk);
      #1;
    end

    // Round robin with 1-word packets on every channel.
    apply_reset();
    load(0, 16'h0A0A, 1); load(0, 16'h0B0B, 1);
    load(1, 16'h1111, 1); load(2, 16'h2222, 1); load(3, 16'h3333, 1);
    push_hdr(0, 0); push_dat(0, 16'h0A0A);
    push_hdr(1, 0); push_dat(1, 16'h1111);
    push_hdr(2, 0); push_dat(2, 16'h2222);
    push_hdr(3, 0); push_dat(3, 16'h3333);
    push_hdr(0, 0); push_dat(0, 16'h0B0B);
    rand_rdy = 1'b0;
    run_stream("round_robin", 200, cyc);
    chk("round_robin_cycles", 32'(cyc), 32'(15));

    // Burst cap: 6-word ch1 packet splits 4+2 with cont on the second header.
    for (int k = 1; k <= 6; k++) load(1, 16'(16'h0100 + k), k == 6);
    load(1, 16'h0107, 1);
    push_hdr(1, 0);
    for (int k = 1; k <= 4; k++) push_dat(1, 16'(16'h0100 + k));
    push_hdr(1, 1);
    push_dat(1, 16'h0105); push_dat(1, 16'h0106);
    push_hdr(1, 0); push_dat(1, 16'h0107);
    run_stream("max_burst", 200, cyc);
    chk("max_burst_cycles", 32'(cyc), 32'(13));

    // Random backpressure on an 8-word ch3 packet; last on the capping word.
    for (int k = 1; k <= 8; k++) load(3, 16'(16'h3000 + k), k == 8);
    load(3, 16'h3009, 1);
    push_hdr(3, 0);
    for (int k = 1; k <= 4; k++) push_dat(3, 16'(16'h3000 + k));
    push_hdr(3, 1);
    for (int k = 5; k <= 8; k++) push_dat(3, 16'(16'h3000 + k));
    push_hdr(3, 0); push_dat(3, 16'h3009);
    rand_rdy = 1'b1;
    run_stream("backpressure", 600, cyc);

    // ch0 drops valid for 5 cycles mid-packet while ch1 waits.
    rand_rdy  = 1'b0;
    gap_at[0] = 1;
    load(0, 16'h00A1, 0); load(0, 16'h00A2, 0); load(0, 16'h00A3, 1);
    load(1, 16'h00B1, 1);
    push_hdr(0, 0);
    push_dat(0, 16'h00A1); push_dat(0, 16'h00A2); push_dat(0, 16'h00A3);
    push_hdr(1, 0); push_dat(1, 16'h00B1);
    run_stream("source_gap", 200, cyc);
    chk("source_gap_cycles", 32'(cyc), 32'(13));
    gap_at[0] = -1;

    // Async reset during the continuation burst of a capped ch1 packet.
    for (int k = 1; k <= 6; k++) load(1, 16'(16'h0C00 + k), k == 6);
    push_hdr(1, 0);
    for (int k = 1; k <= 4; k++) push_dat(1, 16'(16'h0C00 + k));
    push_hdr(1, 1); push_dat(1, 16'h0C05);
    run_stream("pre_reset", 200, cyc);
    chk("pre_rst_mvalid", 32'(bus.m_valid_o), 32'(1));
    chk("pre_rst_busy", 32'(busy), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    reset_checks("async_rst");
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    model_rr   = 0;
    model_cont = '0;
    load(1, 16'h0D01, 1); load(3, 16'h0D03, 1);
    push_hdr(1, 0); push_dat(1, 16'h0D01);
    push_hdr(3, 0); push_dat(3, 16'h0D03);
    run_stream("post_reset", 200, cyc);

    // Randomized traffic against the reference model.
    apply_reset();
    rand_rdy = 1'b1;
    for (int r = 0; r < 8; r++) begin
      total = 0;
      for (int c = 0; c < NCH; c++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 10);
          for (int k = 0; k < len; k++) load(c, 16'($urandom), k == len - 1);
          total += len;
        end
      end
      if (total == 0) load($urandom_range(0, NCH - 1), 16'($urandom), 1);
      model_build();
      run_stream($sformatf("random%0d", r), 3000, cyc);
      total = 0;
      for (int c = 0; c < NCH; c++) total += srcq[c].size();
      chk($sformatf("random%0d_drained", r), 32'(total), 32'(0));
      chk($sformatf("random%0d_busy", r), 32'(busy), 32'(0));
      chk($sformatf("random%0d_grant", r), 32'(grant), 32'(model_last_grant));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
